id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage LA32R core; sits between the fetch stage and EX. Accepts `{inst, pc}` from fetch, decodes the lab instruction subset, reads the register file (which it owns), resolves branches and redirects fetch, and detects RAW hazards against EX/MEM/WB. It also squashes the wrong-path instruction fetched behind a taken branch and drives a packed bundle to EX.

## Interface
- No parameters. Bus widths come from the shared defines `IF2ID_LEN` = 64 and `ID2EX_LEN` = 148.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `if_to_id_valid` in 1: fetch bundle valid.
- `if_to_id_zip` in 64: `{inst[63:32], pc[31:0]}`.
- `id_allowin` out 1: ID can accept this cycle.
- `br_taken` out 1: redirect fetch this cycle.
- `br_target` out 32: redirect PC.
- `ex_allowin` in 1: EX can accept.
- `id_to_ex_valid` out 1: bundle to EX valid.
- `id_to_ex_zip` out 148: `{alu_op[11:0], src1[31:0], src2[31:0], st_data[31:0], dest[4:0], gr_we, mem_we, res_from_mem, pc[31:0]}`, MSB first.
- `ex_fwd` in 39: `{valid, gr_we, dest[4:0], result[31:0]}` from EX. `mem_fwd` and `wb_fwd` are the same format, from MEM and WB.
- `ex_is_load` in 1: the EX instruction is `ld.w`.
- `wb_rf_we` in 1, `wb_rf_waddr` in 5, `wb_rf_wdata` in 32: register-file write port.

## Operation
- **Pipeline register.**
  - `id_valid` and the bundle load on `if_to_id_valid & id_allowin`.
  - `id_valid` clears when the bundle leaves (`id_ready_go & ex_allowin`) and nothing new is loaded.
  - `id_allowin = ~id_valid | (id_ready_go & ex_allowin)`.
- **Decode subset.**
  - R-type: add.w, sub.w, slt, sltu, and, or, nor, xor.
  - Immediate shifts: slli.w, srli.w, srai.w.
  - Other ALU: addi.w, lu12i.w.
  - Memory: ld.w, st.w.
  - Control flow: jirl, b, bl, beq, bne.
  - Any other encoding decodes as a NOP: `gr_we = mem_we = 0`.
- **Sources.**
  - Read port 1 is `rj`.
  - Read port 2 is `rk`, or `rd` for st.w, beq, bne.
  - `src2` is the immediate where applicable: si12 sign-extended, ui5, `si20<<12`, or 4 for bl/jirl link.
  - bl writes r1. jirl writes `rd`. Link instructions use `src1 = pc`.
- **Branch resolution in ID.**
  - Targets:
    - b/bl: `pc + sext(offs26<<2)`.
    - beq/bne: `pc + sext(offs16<<2)`.
    - jirl: `rj + sext(offs16<<2)`.
  - All additions wrap mod 2^32.
  - `br_taken = id_valid & id_ready_go & ex_allowin & taken_cond & ~cancel`.
- **Wrong-path squash.**
  - `cancel` sets when `br_taken` is asserted.
  - The next bundle accepted from fetch is the sequential pc+4. It is loaded with `id_valid = 0`, and `cancel` clears on that same edge.
  - If no bundle arrives, `cancel` holds.
- **Register file (r0..r31).**
  - Write on the clock edge when `wb_rf_we` is set and `waddr != 0`.
  - r0 always reads 0.
  - There is no internal write-through. Same-cycle write/read hazards are handled by the hazard unit.
- **Hazard.**
  - A source matches a stage when: stage `valid & gr_we & dest == src & src != 0`, and the instruction actually uses that source.
  - `id_ready_go = ~stall`.
  - While stalled, `id_to_ex_valid = 0` and `br_taken = 0`.

## Timing
- **Reset values.**
  - `id_valid = 0`, `cancel = 0`.
  - Outputs: `id_to_ex_valid = 0`, `br_taken = 0`, `id_allowin = 1`.
  - Register contents are not reset.
- **Latency.**
  - ID is one stage: a bundle accepted at edge N appears on `id_to_ex_zip` during cycle N+1 (when not stalled).
  - `br_taken` and `br_target` are combinational in the cycle the branch hands off to EX.
- **Back-pressure.** When `ex_allowin = 0`, ID holds its bundle and `id_allowin = 0`. A branch held in ID does not assert `br_taken` until it leaves.
- **Simultaneous events.**
  - A WB write and an ID read of the same register in the same cycle count as a WB hazard (forwarded or stalled).
  - Reset asserted mid-stall or with `cancel = 1` clears everything on that edge.

## Configuration
- **`ID_FORWARD_EN` defined.**
  - Forward from EX, then MEM, then WB (priority in that order, youngest first), otherwise read the register file.
  - Stall only when EX matches and `ex_is_load` is set (one-cycle load-use bubble).
- **`ID_FORWARD_EN` undefined.**
  - Stall on any EX, MEM or WB match.
  - The forwarding inputs' result fields are ignored.

## Structure
- Shared header: `ID2EX_LEN`, the `alu_op` one-hot bit indices, the opcode match constants, and the forward-bus field widths.
- One sub-module, `regfile`: 32×32, two asynchronous read ports, one synchronous write port, r0 hardwired to zero.
- Branch compare, target calculation and hazard/forward muxing stay in `id_stage`.

## Test plan
- **Reset then ALU op.** Assert reset, release, feed addi.w r1,r0,5 at pc 0x1c000000 → next cycle `id_to_ex_valid = 1`, `dest = 1`, `src2 = 5`, `gr_we = 1`.
- **Taken branch with squash.** beq r0,r0,+8 at 0x1c000010 → `br_taken = 1` and `br_target = 0x1c000018` in the handoff cycle. The following bundle (pc 0x1c000014) never asserts `id_to_ex_valid`.
- **Back-pressure on a branch.** Hold `ex_allowin = 0` for 3 cycles with a bne in ID → `br_taken` stays 0 and `id_allowin` stays 0; `br_taken` rises in the cycle `ex_allowin` returns.
- **Load-use.** EX holds ld.w with dest r4; ID holds add.w r5,r4,r4.
  - With `ID_FORWARD_EN`: exactly one stall cycle, then `src1` comes from `mem_fwd`.
  - Without `ID_FORWARD_EN`: stall until r4 has been written back.
- **WB write plus same-cycle read.** `wb_rf_we` writes r7 = 0xdeadbeef while ID reads r7 → with `ID_FORWARD_EN`, `src1 = 0xdeadbeef` in the same cycle. Also write r0 = 0x1234 → r0 still reads 0.
- **bl link.** bl at 0x1c000100 → `dest = 1`, `src1 = 0x1c000100`, `src2 = 4`, redirect to the decoded target.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode constants, bundle layouts and forward-bus helper for id_stage.
// Field widths match the 64-bit IF->ID and 148-bit ID->EX buses.
package id_stage_pkg;

  localparam int IF2ID_LEN = 64;
  localparam int ID2EX_LEN = 148;
  localparam int FWD_LEN   = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // inst[31:15]
  localparam logic [16:0] OP_ADD_W  = 17'h00020;
  localparam logic [16:0] OP_SUB_W  = 17'h00022;
  localparam logic [16:0] OP_SLT    = 17'h00024;
  localparam logic [16:0] OP_SLTU   = 17'h00025;
  localparam logic [16:0] OP_NOR    = 17'h00028;
  localparam logic [16:0] OP_AND    = 17'h00029;
  localparam logic [16:0] OP_OR     = 17'h0002a;
  localparam logic [16:0] OP_XOR    = 17'h0002b;
  localparam logic [16:0] OP_SLLI_W = 17'h00081;
  localparam logic [16:0] OP_SRLI_W = 17'h00089;
  localparam logic [16:0] OP_SRAI_W = 17'h00091;
  // inst[31:22]
  localparam logic [9:0]  OP_ADDI_W = 10'h00a;
  localparam logic [9:0]  OP_LD_W   = 10'h0a2;
  localparam logic [9:0]  OP_ST_W   = 10'h0a6;
  // inst[31:25]
  localparam logic [6:0]  OP_LU12I  = 7'h0a;
  // inst[31:26]
  localparam logic [5:0]  OP_JIRL   = 6'h13;
  localparam logic [5:0]  OP_B      = 6'h14;
  localparam logic [5:0]  OP_BL     = 6'h15;
  localparam logic [5:0]  OP_BEQ    = 6'h16;
  localparam logic [5:0]  OP_BNE    = 6'h17;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st_data;
    logic [4:0]  dest;
    logic        gr_we;
    logic        mem_we;
    logic        res_from_mem;
    logic [31:0] pc;
  } id_ex_t;

  function automatic logic fwd_hit(
    input fwd_t       f,
    input logic [4:0] a
  );
    return f.valid & f.gr_we & (f.dest == a) & (a != 5'd0);
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// r0 reads as zero and ignores writes; no write-through.
module regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] rf [32];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) rf[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/id_stage.sv
// LA32R decode stage: decode, regfile read, branch resolve, hazard detect.
// Define ID_FORWARD_EN for EX/MEM/WB forwarding with load-use stall only.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_to_id_valid,
  input  logic [IF2ID_LEN-1:0] if_to_id_zip,
  output logic                 id_allowin,
  output logic                 br_taken,
  output logic [31:0]          br_target,
  input  logic                 ex_allowin,
  output logic                 id_to_ex_valid,
  output logic [ID2EX_LEN-1:0] id_to_ex_zip,
  input  logic [FWD_LEN-1:0]   ex_fwd,
  input  logic [FWD_LEN-1:0]   mem_fwd,
  input  logic [FWD_LEN-1:0]   wb_fwd,
  input  logic                 ex_is_load,
  input  logic                 wb_rf_we,
  input  logic [4:0]           wb_rf_waddr,
  input  logic [31:0]          wb_rf_wdata
);

  logic        id_valid;
  logic        cancel;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        id_ready_go;
  logic        stall;
  logic        accept;

  assign id_allowin = ~id_valid | (id_ready_go & ex_allowin);
  assign accept     = if_to_id_valid & id_allowin;

  // A bundle arriving on the redirect edge is the wrong-path one.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      cancel   <= 1'b0;
    end else begin
      if (accept)
        id_valid <= ~cancel & ~br_taken;
      else if (id_ready_go & ex_allowin)
        id_valid <= 1'b0;
      if (accept)
        cancel <= 1'b0;
      else if (br_taken)
        cancel <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) {inst, pc} <= if_to_id_zip;
  end

  logic [4:0] rd, rj, rk;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  logic is_add, is_sub, is_slt, is_sltu;
  logic is_and, is_or, is_nor, is_xor;
  logic is_slli, is_srli, is_srai;
  logic is_addi, is_lu12i, is_ld, is_st;
  logic is_jirl, is_b, is_bl, is_beq, is_bne;
  logic rtype, shift;

  assign is_add   = inst[31:15] == OP_ADD_W;
  assign is_sub   = inst[31:15] == OP_SUB_W;
  assign is_slt   = inst[31:15] == OP_SLT;
  assign is_sltu  = inst[31:15] == OP_SLTU;
  assign is_and   = inst[31:15] == OP_AND;
  assign is_or    = inst[31:15] == OP_OR;
  assign is_nor   = inst[31:15] == OP_NOR;
  assign is_xor   = inst[31:15] == OP_XOR;
  assign is_slli  = inst[31:15] == OP_SLLI_W;
  assign is_srli  = inst[31:15] == OP_SRLI_W;
  assign is_srai  = inst[31:15] == OP_SRAI_W;
  assign is_addi  = inst[31:22] == OP_ADDI_W;
  assign is_ld    = inst[31:22] == OP_LD_W;
  assign is_st    = inst[31:22] == OP_ST_W;
  assign is_lu12i = inst[31:25] == OP_LU12I;
  assign is_jirl  = inst[31:26] == OP_JIRL;
  assign is_b     = inst[31:26] == OP_B;
  assign is_bl    = inst[31:26] == OP_BL;
  assign is_beq   = inst[31:26] == OP_BEQ;
  assign is_bne   = inst[31:26] == OP_BNE;

  assign rtype = is_add | is_sub | is_slt | is_sltu
               | is_and | is_or | is_nor | is_xor;
  assign shift = is_slli | is_srli | is_srai;

  logic [11:0] alu_op;
  assign alu_op[ALU_ADD]  = is_add | is_addi | is_ld
                          | is_st | is_jirl | is_bl;
  assign alu_op[ALU_SUB]  = is_sub;
  assign alu_op[ALU_SLT]  = is_slt;
  assign alu_op[ALU_SLTU] = is_sltu;
  assign alu_op[ALU_AND]  = is_and;
  assign alu_op[ALU_NOR]  = is_nor;
  assign alu_op[ALU_OR]   = is_or;
  assign alu_op[ALU_XOR]  = is_xor;
  assign alu_op[ALU_SLL]  = is_slli;
  assign alu_op[ALU_SRL]  = is_srli;
  assign alu_op[ALU_SRA]  = is_srai;
  assign alu_op[ALU_LUI]  = is_lu12i;

  logic [31:0] si12, ui5, si20, offs16, offs26;
  assign si12   = {{20{inst[21]}}, inst[21:10]};
  assign ui5    = {27'd0, inst[14:10]};
  assign si20   = {inst[24:5], 12'd0};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

  logic [31:0] imm;
  logic        use1, use2, r2_rd;
  logic        src1_pc, src2_imm, dest_r1;
  logic        gr_we, mem_we, res_from_mem;

  always_comb begin
    imm          = 32'd0;
    use1         = 1'b0;
    use2         = 1'b0;
    r2_rd        = 1'b0;
    src1_pc      = 1'b0;
    src2_imm     = 1'b0;
    dest_r1      = 1'b0;
    gr_we        = 1'b0;
    mem_we       = 1'b0;
    res_from_mem = 1'b0;
    unique case (1'b1)
      rtype: begin
        use1  = 1'b1;
        use2  = 1'b1;
        gr_we = 1'b1;
      end
      shift: begin
        use1     = 1'b1;
        imm      = ui5;
        src2_imm = 1'b1;
        gr_we    = 1'b1;
      end
      is_addi: begin
        use1     = 1'b1;
        imm      = si12;
        src2_imm = 1'b1;
        gr_we    = 1'b1;
      end
      is_lu12i: begin
        imm      = si20;
        src2_imm = 1'b1;
        gr_we    = 1'b1;
      end
      is_ld: begin
        use1         = 1'b1;
        imm          = si12;
        src2_imm     = 1'b1;
        gr_we        = 1'b1;
        res_from_mem = 1'b1;
      end
      is_st: begin
        use1     = 1'b1;
        use2     = 1'b1;
        r2_rd    = 1'b1;
        imm      = si12;
        src2_imm = 1'b1;
        mem_we   = 1'b1;
      end
      is_jirl: begin
        use1     = 1'b1;
        src1_pc  = 1'b1;
        imm      = 32'd4;
        src2_imm = 1'b1;
        gr_we    = 1'b1;
      end
      is_bl: begin
        src1_pc  = 1'b1;
        imm      = 32'd4;
        src2_imm = 1'b1;
        gr_we    = 1'b1;
        dest_r1  = 1'b1;
      end
      is_beq, is_bne: begin
        use1  = 1'b1;
        use2  = 1'b1;
        r2_rd = 1'b1;
      end
      default: ;
    endcase
  end

  logic [4:0]  raddr2;
  logic [31:0] rdata1, rdata2;
  assign raddr2 = r2_rd ? rd : rk;

  regfile u_rf (
    .clk    (clk),
    .raddr1 (rj),
    .rdata1 (rdata1),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .we     (wb_rf_we),
    .waddr  (wb_rf_waddr),
    .wdata  (wb_rf_wdata)
  );

  fwd_t exf, memf, wbf;
  assign exf  = ex_fwd;
  assign memf = mem_fwd;
  assign wbf  = wb_fwd;

  logic e1, m1, w1, e2, m2, w2;
  assign e1 = use1 & fwd_hit(exf, rj);
  assign m1 = use1 & fwd_hit(memf, rj);
  assign w1 = use1 & fwd_hit(wbf, rj);
  assign e2 = use2 & fwd_hit(exf, raddr2);
  assign m2 = use2 & fwd_hit(memf, raddr2);
  assign w2 = use2 & fwd_hit(wbf, raddr2);

  logic [31:0] r1_val, r2_val;

`ifdef ID_FORWARD_EN
  assign r1_val = e1 ? exf.result
                : m1 ? memf.result
                : w1 ? wbf.result
                : rdata1;
  assign r2_val = e2 ? exf.result
                : m2 ? memf.result
                : w2 ? wbf.result
                : rdata2;
  assign stall  = ex_is_load & (e1 | e2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exf.result, memf.result,
                        wbf.result, ex_is_load};
  assign r1_val = rdata1;
  assign r2_val = rdata2;
  assign stall  = e1 | m1 | w1 | e2 | m2 | w2;
`endif

  assign id_ready_go = ~stall;

  logic taken_cond;
  assign taken_cond = is_b | is_bl | is_jirl
                    | (is_beq & (r1_val == r2_val))
                    | (is_bne & (r1_val != r2_val));

  assign br_target = (is_jirl ? r1_val : pc)
                   + ((is_b | is_bl) ? offs26 : offs16);
  assign br_taken  = id_valid & id_ready_go & ex_allowin
                   & taken_cond & ~cancel;

  assign id_to_ex_valid = id_valid & id_ready_go;

  id_ex_t bundle;
  always_comb begin
    bundle.alu_op       = alu_op;
    bundle.src1         = src1_pc ? pc : r1_val;
    bundle.src2         = src2_imm ? imm : r2_val;
    bundle.st_data      = r2_val;
    bundle.dest         = dest_r1 ? 5'd1 : rd;
    bundle.gr_we        = gr_we;
    bundle.mem_we       = mem_we;
    bundle.res_from_mem = res_from_mem;
    bundle.pc           = pc;
  end
  assign id_to_ex_zip = bundle;

endmodule
